// File: rtl/j1_flash_loader.sv
// j1_flash_loader
// Boot loader for the j1 core. Holds the CPU in reset, reads WORDS 16-bit words
// from SPI flash (mode 0, SCK generated here) starting at FLASH_OFFSET, writes
// them into RAM words 0..WORDS-1, then releases the CPU. A reload pulse in DONE
// repeats the whole sequence.
//
// Ports:
//   clk        system clock
//   resetq     synchronous active-low reset
//   reload     one-cycle reload request, honoured only in DONE
//   spi_csn    flash chip select (active low)
//   spi_sck    SPI clock, idles low
//   spi_mosi   command bits to flash
//   spi_miso   data bits from flash, sampled as SCK rises
//   ram_addr   RAM word address (valid with ram_wr)
//   ram_wdata  RAM write data   (valid with ram_wr)
//   ram_wr     one-cycle RAM write strobe
//   cpu_reset  active-high reset to the j1, high until the image is loaded
//   done       high once the image is loaded
//
// Load time: counting clk edges with resetq high (or from the edge that accepts
// reload), done is first high after edge
//   2*CLKDIV + (32 + 16*WORDS)*2*CLKDIV - CLKDIV + 1.
// The final bit is sampled on its rising SCK edge; the write and DONE follow on
// the next two edges without waiting out the second half of that bit.
module j1_flash_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h010000,
  parameter int          WORDS        = 8192,
  parameter int          CLKDIV       = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        reload,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_wr,
  output logic        cpu_reset,
  output logic        done
);

  typedef enum logic [2:0] {S_START, S_CMD, S_DATA, S_WRITE, S_DONE} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLKDIV - 1);
  localparam logic [15:0] DESEL_LAST = 16'(2 * CLKDIV - 1);
  localparam logic [13:0] IDX_LAST   = 14'(WORDS - 1);

  state_t      r_state, w_next;
  logic [15:0] r_div;
  logic        r_sck;
  logic [4:0]  r_bit;
  logic [31:0] r_cmd;
  logic [14:0] r_shift;
  logic [13:0] r_idx;
  logic [13:0] r_addr;
  logic [15:0] r_wdata;

  logic        w_tick, w_rise, w_fall, w_spi_on;
  logic [15:0] w_shift_nx;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_rise     = w_tick & ~r_sck;
  assign w_fall     = w_tick &  r_sck;
  assign w_shift_nx = {r_shift, spi_miso};
  // SCK keeps running through WRITE so the next word follows without a gap.
  assign w_spi_on   = (w_next == S_CMD) || (w_next == S_DATA) || (w_next == S_WRITE);

  // State register
  always_ff @(posedge clk) begin
    if (!resetq) r_state <= S_START;
    else         r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START: if (r_div == DESEL_LAST)         w_next = S_CMD;
      S_CMD:   if (w_fall && r_bit == 5'd31)    w_next = S_DATA;
      S_DATA:  if (w_rise && r_bit == 5'd15)    w_next = S_WRITE;
      S_WRITE: w_next = (r_idx == IDX_LAST) ? S_DONE : S_DATA;
      S_DONE:  if (reload)                      w_next = S_START;
      default: w_next = S_START;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    spi_csn   = 1'b1;
    spi_mosi  = 1'b0;
    ram_wr    = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_CMD:   begin spi_csn = 1'b0; spi_mosi = r_cmd[31]; end
      S_DATA:  spi_csn = 1'b0;
      S_WRITE: begin spi_csn = 1'b0; ram_wr = 1'b1; end
      S_DONE:  begin cpu_reset = 1'b0; done = 1'b1; end
      default: ;
    endcase
  end

  assign spi_sck   = r_sck;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  // Datapath: SCK divider, command shifter, data shifter, word index
  always_ff @(posedge clk) begin
    if (!resetq) begin
      r_div   <= '0;
      r_sck   <= 1'b0;
      r_bit   <= '0;
      r_cmd   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      // START reuses the divider as the deselect timer; it wraps to 0 exactly
      // as CMD begins, so the first SCK rise lands CLKDIV cycles after CSN falls.
      if (r_state == S_START) begin
        r_div <= (r_div == DESEL_LAST) ? 16'd0 : r_div + 16'd1;
        r_sck <= 1'b0;
      end else if (w_spi_on) begin
        if (w_tick) begin
          r_div <= 16'd0;
          r_sck <= ~r_sck;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end else begin
        r_div <= 16'd0;
        r_sck <= 1'b0;
      end

      case (r_state)
        S_START: begin
          r_bit <= '0;
          r_cmd <= {8'h03, FLASH_OFFSET};
        end
        S_CMD: if (w_fall) begin
          r_cmd <= {r_cmd[30:0], 1'b0};
          r_bit <= r_bit + 5'd1;   // wraps to 0 on the 32nd bit, ready for DATA
        end
        S_DATA: if (w_rise) begin
          r_shift <= w_shift_nx[14:0];
          if (r_bit == 5'd15) begin
            r_bit   <= 5'd0;
            // first byte off the wire is the low byte
            r_wdata <= {w_shift_nx[7:0], w_shift_nx[15:8]};
            r_addr  <= r_idx;
          end else begin
            r_bit <= r_bit + 5'd1;
          end
        end
        S_WRITE: if (r_idx != IDX_LAST) r_idx <= r_idx + 14'd1;
        S_DONE:  if (reload) r_idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_flash_loader.sv
module tb_j1_flash_loader;

  localparam int NI = 5;
  localparam int          W_T      [NI] = '{4, 3, 2, 8, 1};
  localparam int          C_T      [NI] = '{2, 1, 3, 1, 2};
  localparam logic [23:0] OFF_T    [NI] = '{24'h010000, 24'h123456, 24'hABCDEF, 24'h000100, 24'hFFFF00};
  localparam logic [31:0] CMD_LIT  [NI] = '{32'h03010000, 32'h03123456, 32'h03ABCDEF, 32'h03000100, 32'h03FFFF00};
  localparam int          DONE_LIT [NI] = '{387, 162, 388, 322, 195};
  localparam logic [7:0]  FIX  [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  localparam logic [15:0] EXP0 [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int          W     = W_T[g];
    localparam int          C     = C_T[g];
    localparam logic [23:0] OFF   = OFF_T[g];
    localparam logic [31:0] CMD32 = {8'h03, OFF};
    // load-complete edge count, from the bit-timing rules
    localparam int          N     = 2*C + (32 + 16*W)*2*C - C + 1;
    localparam int          RSTPT = 32 + 16*((W - 1)/2) + 9;

    logic resetq = 1'b0, reload = 1'b0, miso = 1'b0;
    logic csn, sck, mosi, wr, cpu_rst, dn;
    logic [13:0] addr;
    logic [15:0] wdata;

    j1_flash_loader #(.FLASH_OFFSET(OFF), .WORDS(W), .CLKDIV(C)) dut (
      .clk(clk), .resetq(resetq), .reload(reload),
      .spi_csn(csn), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso),
      .ram_addr(addr), .ram_wdata(wdata), .ram_wr(wr),
      .cpu_reset(cpu_rst), .done(dn)
    );

    logic [7:0] img [2*W];
    bit fixed = 1'b0, fin = 1'b0, rq_s = 1'b0, rl_s = 1'b0;
    int cyc = 0, nrise = 0, nfall = 0, ncmd = 0, last_wr = 0;
    logic psck = 1'b0, pcsn = 1'b1, pdn = 1'b0;
    logic [31:0] cmd = '0;

    always @(posedge clk) begin
      rq_s <= resetq;
      rl_s <= reload;
    end

    // Flash model plus per-cycle reference: every output is a function of the
    // number of edges since the load began.
    always @(negedge clk) begin
      int t, u, w, d;
      bit act, ewr, emosi;
      if (!rq_s) begin
        cyc = 0;
        chk("rst_addr",  g, 32'(addr),  32'h0);
        chk("rst_wdata", g, 32'(wdata), 32'h0);
      end else if (rl_s && cyc >= N) begin
        cyc = 0;
      end else begin
        cyc++;
      end

      if (csn) begin
        if (!pcsn && rq_s) chk("bits_per_load", g, 32'(nrise), 32'(32 + 16*W));
        nrise = 0; nfall = 0; cmd = '0; miso = 1'b0;
      end else begin
        if (sck && !psck) begin
          if (nrise < 32) cmd = {cmd[30:0], mosi};
          nrise++;
          if (nrise == 32) begin
            chk("cmd", g, cmd, CMD_LIT[g]);
            ncmd++;
          end
        end
        if (!sck && psck) begin
          nfall++;
          if (nfall >= 32) begin
            d = nfall - 32;
            miso = (d/8 < 2*W) ? img[d/8][7 - d%8] : 1'b0;
          end
        end
      end

      t     = cyc - 2*C;
      act   = (cyc >= 2*C) && (cyc < N);
      u     = t - 95*C;
      ewr   = act && (u >= 0) && (u % (32*C) == 0) && (u / (32*C) < W);
      w     = ewr ? u / (32*C) : 0;
      emosi = 1'b0;
      if (act && t < 64*C) emosi = CMD32[31 - t/(2*C)];

      chk("spi_csn",   g, 32'(csn),     32'(!act));
      chk("spi_sck",   g, 32'(sck),     32'(act && (t % (2*C) >= C)));
      chk("spi_mosi",  g, 32'(mosi),    32'(emosi));
      chk("ram_wr",    g, 32'(wr),      32'(ewr));
      chk("done",      g, 32'(dn),      32'(cyc >= N));
      chk("cpu_reset", g, 32'(cpu_rst), 32'(cyc < N));
      if (ewr) begin
        chk("ram_addr",  g, 32'(addr),  32'(w));
        chk("ram_wdata", g, 32'(wdata), 32'({img[2*w+1], img[2*w]}));
        if (fixed) chk("wdata_lit", g, 32'(wdata), 32'(EXP0[w]));
      end
      if (wr) last_wr = cyc;
      if (dn && !pdn) begin
        chk("wr_to_done", g, 32'(cyc - last_wr), 32'd1);
        chk("done_cycle", g, 32'(cyc), 32'(DONE_LIT[g]));
      end
      psck = sck; pcsn = csn; pdn = dn;
    end

    initial begin : drv
      int rnd;
      bit ok;
      fixed = (g == 0);
      for (int i = 0; i < 2*W; i++) img[i] = (fixed && i < 8) ? FIX[i] : 8'($urandom);
      repeat (3) @(posedge clk);
      #1 resetq = 1'b1;

      // reload while streaming data must be ignored
      rnd = $urandom_range(78*C, 68*C);
      repeat (rnd) @(posedge clk);
      #1 reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;

      // abort mid-word with reset
      ok = 1'b0;
      for (int i = 0; i < 4*N; i++) begin
        @(posedge clk);
        if (nrise == RSTPT) begin ok = 1'b1; break; end
      end
      chk("reach_reset_point", g, 32'(ok), 32'd1);
      #1 resetq = 1'b0;
      @(posedge clk);
      #1 resetq = 1'b1;

      ok = 1'b0;
      for (int i = 0; i < 2*N; i++) begin
        @(posedge clk);
        if (dn === 1'b1) begin ok = 1'b1; break; end
      end
      chk("load_done", g, 32'(ok), 32'd1);

      repeat (5) @(posedge clk);
      #1 reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2*N; i++) begin
        @(posedge clk);
        if (dn === 1'b1) begin ok = 1'b1; break; end
      end
      chk("reload_done", g, 32'(ok), 32'd1);
      repeat (3) @(posedge clk);
      // aborted load, reloaded load after reset, explicit reload
      chk("cmd_count", g, 32'(ncmd), 32'd3);
      fin = 1'b1;
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int i = 0; i < 20000 && !all; i++) begin
      @(posedge clk);
      all = gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin && gi[4].fin;
    end
    chk("all_finished", -1, 32'(all), 32'd1);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
